// File: rtl/eth_reset_sequencer.sv
// Ethernet clock-domain reset sequencer: staged per-domain release after lock.
// Optional lock-timeout flag enabled by defining ETH_RST_SEQ_LOCK_TIMEOUT_EN.
module eth_reset_sequencer #(
    parameter int num_domains_p  = 3,
    parameter int hold_cycles_p  = 16,
    parameter int lock_timeout_p = 1024
) (
    input  logic                     clk_i,
    input  logic                     async_reset_i,
    input  logic                     lock_i,
    input  logic                     sw_reset_v_i,
    output logic                     sw_reset_ready_and_o,
    output logic [num_domains_p-1:0] reset_o,
    output logic                     done_o,
    output logic                     timeout_o
);

    localparam int cnt_max_lp = (hold_cycles_p > lock_timeout_p)
                              ? hold_cycles_p : lock_timeout_p;
    localparam int cnt_w_lp   = $clog2(cnt_max_lp + 1);
    localparam int stage_w_lp = (num_domains_p > 1) ? $clog2(num_domains_p) : 1;

    localparam logic [cnt_w_lp-1:0]   hold_last_lp  = cnt_w_lp'(hold_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0]   cnt_sat_lp    = cnt_w_lp'(cnt_max_lp);
    localparam logic [stage_w_lp-1:0] stage_last_lp = stage_w_lp'(num_domains_p - 1);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_RELEASE,
        S_DONE,
        S_ASSERT
    } state_e;

    (* ASYNC_REG = "TRUE" *) logic rst_meta;
    (* ASYNC_REG = "TRUE" *) logic sync_rst;
    (* ASYNC_REG = "TRUE" *) logic lock_meta;
    (* ASYNC_REG = "TRUE" *) logic lock_s;

    state_e                   state_q, state_n;
    logic [cnt_w_lp-1:0]      cnt_q, cnt_n, cnt_inc;
    logic [stage_w_lp-1:0]    stage_q, stage_n;
    logic [num_domains_p-1:0] reset_q, reset_n;
    logic                     accept;
    logic                     lock_lost;

    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            rst_meta <= 1'b1;
            sync_rst <= 1'b1;
        end else begin
            rst_meta <= 1'b0;
            sync_rst <= rst_meta;
        end
    end

    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= lock_i;
            lock_s    <= lock_meta;
        end
    end

    assign sw_reset_ready_and_o = (state_q == S_WAIT_LOCK) ||
                                  (state_q == S_RELEASE) ||
                                  (state_q == S_DONE);
    assign accept    = sw_reset_v_i && sw_reset_ready_and_o;
    assign lock_lost = !lock_s &&
                       ((state_q == S_RELEASE) || (state_q == S_DONE));
    assign cnt_inc   = (cnt_q == cnt_sat_lp) ? cnt_q : cnt_q + 1'b1;

`ifdef ETH_RST_SEQ_LOCK_TIMEOUT_EN
    logic timeout_q, timeout_n;
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        stage_n = stage_q;
        reset_n = reset_q;
`ifdef ETH_RST_SEQ_LOCK_TIMEOUT_EN
        timeout_n = timeout_q;
`endif
        unique case (state_q)
            S_RESET: begin
                cnt_n   = '0;
                stage_n = '0;
                if (!sync_rst) state_n = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    state_n = S_RELEASE;
                    cnt_n   = '0;
                    stage_n = '0;
                end
`ifdef ETH_RST_SEQ_LOCK_TIMEOUT_EN
                // Timer freezes once the sticky flag is up
                else if (!timeout_q) begin
                    if (cnt_q == cnt_w_lp'(lock_timeout_p - 1))
                        timeout_n = 1'b1;
                    else
                        cnt_n = cnt_inc;
                end
`endif
            end
            S_RELEASE: begin
                if (cnt_q == hold_last_lp) begin
                    reset_n[stage_q] = 1'b0;
                    cnt_n            = '0;
                    if (stage_q == stage_last_lp)
                        state_n = S_DONE;
                    else
                        stage_n = stage_q + 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            S_DONE: begin
            end
            S_ASSERT: begin
                if (cnt_q == hold_last_lp) begin
                    state_n = S_WAIT_LOCK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: state_n = S_RESET;
        endcase

        // Software request and lock loss share one re-assert path
        if (accept || lock_lost) begin
            state_n = S_ASSERT;
            cnt_n   = '0;
            stage_n = '0;
            reset_n = '1;
        end
`ifdef ETH_RST_SEQ_LOCK_TIMEOUT_EN
        if (accept) timeout_n = 1'b0;
`endif
    end

    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            stage_q <= '0;
            reset_q <= '1;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            stage_q <= stage_n;
            reset_q <= reset_n;
        end
    end

`ifdef ETH_RST_SEQ_LOCK_TIMEOUT_EN
    always_ff @(posedge clk_i or posedge async_reset_i) begin
        if (async_reset_i) timeout_q <= 1'b0;
        else               timeout_q <= timeout_n;
    end
`endif

    assign reset_o = reset_q;
    assign done_o  = (state_q == S_DONE);

endmodule
